// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin lock arbiter.
package arb_pkg;

  // Reset value of the priority pointer: requester 0 starts with top priority.
  // Sliced to the arbiter width by the user.
  localparam logic [63:0] PRIO_RST = 64'd1;

  // Ceiling log2, used to confirm the hold counter can reach MAXHOLD-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic priority picker. The winner is the first set req bit at
// or above the one-hot prio bit, wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] prio,
  output logic [N-1:0] win,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] dbl_sub;
  logic [2*N-1:0] dbl_win;

  // Doubled-vector borrow chain: subtracting prio clears the first request at
  // or above it; the upper copy catches the wrap-around case.
  always_comb begin
    dbl     = {req, req};
    dbl_sub = dbl - {{N{1'b0}}, prio};
    dbl_win = dbl & ~dbl_sub;
    win     = dbl_win[N-1:0] | dbl_win[2*N-1:N];
    any     = |req;
  end

endmodule

// File: rtl/rr_lock_arb.sv
// Round-robin arbiter with registered one-hot grant, a rotating priority
// pointer and a bounded per-requester lock (hold) mode.
//
// Handshake: a requester owns the resource in every cycle its g bit is high.
// There is no acknowledge; g is a pure function of state registered on the
// clock edge at which req/lock are sampled. en=0 freezes all state.
module rr_lock_arb
  import arb_pkg::*;
#(
  parameter int N       = 8,
  parameter int MAXHOLD = 4,
  parameter int CW      = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic [N-1:0] lock,
  output logic [N-1:0] g,
  output logic         gvalid,
  output logic [N-1:0] prio
);

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAXHOLD - 1);

  if ((CW < clog2(MAXHOLD)) || (MAXHOLD < 1)) begin : g_param_check
    $error("rr_lock_arb: CW too narrow for MAXHOLD, or MAXHOLD < 1");
  end

  logic [N-1:0]  g_q, g_d;
  logic [N-1:0]  prio_q, prio_d;
  logic          gvalid_q, gvalid_d;
  logic [CW-1:0] holdcnt_q, holdcnt_d;

  logic [N-1:0]  win;
  logic          any;
  logic          hold_ok;

  rr_pick #(.N(N)) u_pick (
    .req  (req),
    .prio (prio_q),
    .win  (win),
    .any  (any)
  );

  // The current holder keeps its grant while it still requests and locks and
  // has not used up its hold budget; otherwise arbitrate afresh.
  always_comb begin
    hold_ok   = (MAXHOLD > 1) && (|(g_q & req & lock)) && (holdcnt_q < HOLD_LAST);
    g_d       = g_q;
    prio_d    = prio_q;
    gvalid_d  = gvalid_q;
    holdcnt_d = holdcnt_q;
    if (en) begin
      if (hold_ok) begin
        holdcnt_d = holdcnt_q + CW'(1);
      end else begin
        holdcnt_d = '0;
        if (any) begin
          g_d      = win;
          prio_d   = {win[N-2:0], win[N-1]};
          gvalid_d = 1'b1;
        end else begin
          g_d      = '0;
          gvalid_d = 1'b0;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q       <= '0;
      prio_q    <= PRIO_RST[N-1:0];
      gvalid_q  <= 1'b0;
      holdcnt_q <= '0;
    end else begin
      g_q       <= g_d;
      prio_q    <= prio_d;
      gvalid_q  <= gvalid_d;
      holdcnt_q <= holdcnt_d;
    end
  end

  assign g      = g_q;
  assign gvalid = gvalid_q;
  assign prio   = prio_q;

endmodule

// File: tb/tb_rr_lock_arb.sv
// Directed bench for rr_lock_arb: N=4 with MAXHOLD=3 (dut_a) and MAXHOLD=1
// (dut_b). Drivers push expected results; negedge monitors pop and compare.
module tb_rr_lock_arb;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         en_a, en_b;
  logic [N-1:0] req_a, lock_a, req_b, lock_b;
  logic [N-1:0] g_a, prio_a, g_b, prio_b;
  logic         gvalid_a, gvalid_b;

  int checks;
  int errors;
  bit b_push;

  // {holdcnt[1:0], gvalid, g[3:0], prio[3:0]}
  logic [10:0] exp_q[$];
  // {gvalid, g[3:0], prio[3:0]}
  logic [8:0]  exp_b_q[$];

  rr_lock_arb #(.N(N), .MAXHOLD(3), .CW(2)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .en     (en_a),
    .req    (req_a),
    .lock   (lock_a),
    .g      (g_a),
    .gvalid (gvalid_a),
    .prio   (prio_a)
  );

  rr_lock_arb #(.N(N), .MAXHOLD(1), .CW(2)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .en     (en_b),
    .req    (req_b),
    .lock   (lock_b),
    .g      (g_b),
    .gvalid (gvalid_b),
    .prio   (prio_b)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clocked cycle for dut_a; expected state after the edge is queued.
  task automatic cycle(input logic e, input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [N-1:0] eg, input logic [N-1:0] ep, input logic [1:0] eh);
    en_a   = e;
    req_a  = r;
    lock_a = l;
    @(posedge clk);
    exp_q.push_back({eh, |eg, eg, ep});
    if (b_push) exp_b_q.push_back({|eg, eg, ep});
    @(negedge clk);
  endtask

  // Monitor for dut_a
  always @(negedge clk) begin
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("a_g",       16'(g_a),              16'(e[7:4]));
      chk("a_gvalid",  16'(gvalid_a),         16'(e[8]));
      chk("a_prio",    16'(prio_a),           16'(e[3:0]));
      chk("a_holdcnt", 16'(dut_a.holdcnt_q),  16'(e[10:9]));
      chk("a_holdcnt_bound", 16'(dut_a.holdcnt_q > 2'd2), 16'd0);
    end
  end

  // Monitor for dut_b
  always @(negedge clk) begin
    logic [8:0] e;
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      chk("b_g",      16'(g_b),      16'(e[7:4]));
      chk("b_gvalid", 16'(gvalid_b), 16'(e[8]));
      chk("b_prio",   16'(prio_b),   16'(e[3:0]));
    end
  end

  // Stimulus
  initial begin
    checks = 0;
    errors = 0;
    b_push = 1'b0;
    rst = 1'b1;
    en_a = 1'b0; req_a = '0; lock_a = '0;
    en_b = 1'b0; req_b = '0; lock_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fair rotation; dut_b (MAXHOLD=1) gets lock=1111 and must match
    b_push = 1'b1;
    en_b = 1'b1; req_b = 4'b1111; lock_b = 4'b1111;
    cycle(1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 2'd0);
    cycle(1'b1, 4'b1111, 4'b0000, 4'b0010, 4'b0100, 2'd0);
    cycle(1'b1, 4'b1111, 4'b0000, 4'b0100, 4'b1000, 2'd0);
    cycle(1'b1, 4'b1111, 4'b0000, 4'b1000, 4'b0001, 2'd0);
    cycle(1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 2'd0);

    // Mid-cycle asynchronous reset: effect must be visible before any edge
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_g",      16'(g_a),             16'd0);
    chk("rst_async_gvalid", 16'(gvalid_a),        16'd0);
    chk("rst_async_prio",   16'(prio_a),          16'b0001);
    chk("rst_async_hold",   16'(dut_a.holdcnt_q), 16'd0);
    chk("rst_async_b_g",    16'(g_b),             16'd0);
    chk("rst_async_b_prio", 16'(prio_b),          16'b0001);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    req_b = 4'b0000; lock_b = 4'b0000;
    cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0);
    cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0);
    b_push = 1'b0;
    en_b = 1'b0;

    // Bounded lock, then wrap past bit 3
    cycle(1'b1, 4'b0101, 4'b0001, 4'b0001, 4'b0010, 2'd0);
    cycle(1'b1, 4'b0101, 4'b0001, 4'b0001, 4'b0010, 2'd1);
    cycle(1'b1, 4'b0101, 4'b0001, 4'b0001, 4'b0010, 2'd2);
    cycle(1'b1, 4'b0101, 4'b0001, 4'b0100, 4'b1000, 2'd0);
    cycle(1'b1, 4'b0101, 4'b0001, 4'b0001, 4'b0010, 2'd0);

    // Early release: holder 1 drops req, next grant without a gap
    cycle(1'b1, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 2'd0);
    cycle(1'b1, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 2'd1);
    cycle(1'b1, 4'b1100, 4'b0010, 4'b0100, 4'b1000, 2'd0);

    // Freeze with changing inputs, then enabled idle
    cycle(1'b0, 4'b1111, 4'b1111, 4'b0100, 4'b1000, 2'd0);
    cycle(1'b0, 4'b0011, 4'b0000, 4'b0100, 4'b1000, 2'd0);
    cycle(1'b0, 4'b1000, 4'b1000, 4'b0100, 4'b1000, 2'd0);
    cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 2'd0);

    // Sole locked requester: holdcnt cycles 0,1,2,0,1
    cycle(1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 2'd0);
    cycle(1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 2'd1);
    cycle(1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 2'd2);
    cycle(1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 2'd0);
    cycle(1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 2'd1);

    // Freeze in mid-hold keeps holdcnt, then resume to the limit
    cycle(1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 2'd1);
    cycle(1'b0, 4'b1011, 4'b0000, 4'b0100, 4'b1000, 2'd1);
    cycle(1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 2'd2);

    // Lock on a non-holder is ignored; lock on the new holder takes effect
    cycle(1'b1, 4'b0011, 4'b0010, 4'b0001, 4'b0010, 2'd0);
    cycle(1'b1, 4'b0011, 4'b0010, 4'b0010, 4'b0100, 2'd0);
    cycle(1'b1, 4'b0011, 4'b0010, 4'b0010, 4'b0100, 2'd1);

    // Drain and confirm every expected entry was consumed
    repeat (2) @(negedge clk);
    chk("a_queue_drained", 16'(exp_q.size()),   16'd0);
    chk("b_queue_drained", 16'(exp_b_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
